// File: rtl/sp_ram_dma_pkg.sv
// Shared types and constants for the single-port RAM stream DMA.
package sp_ram_dma_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StRdDrain,
        StWr,
        StDone
    } dma_state_t;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [3:0]  BE_ALL     = 4'hF;

    // One read-return buffer entry: RAM word plus end-of-command marker.
    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } dma_word_t;

endpackage

// File: rtl/dma_stream_fifo.sv
// Small synchronous FIFO holding RAM read returns ahead of the output stream.
module dma_stream_fifo
    import sp_ram_dma_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    push_i,
    input  dma_word_t               wdata_i,
    input  logic                    pop_i,
    output dma_word_t               rdata_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    dma_word_t             mem_q [DEPTH];
    logic [PtrW-1:0]       wptr_q, wptr_d;
    logic [PtrW-1:0]       rptr_q, rptr_d;
    logic [CntW-1:0]       count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_i) begin
            wptr_d = wptr_q + PtrW'(1);
        end
        if (pop_i) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CntW'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/sp_ram_stream_dma.sv
// Block mover between a single-port RAM (1-cycle read latency) and valid/ready streams.
module sp_ram_stream_dma
    import sp_ram_dma_pkg::*;
#(
    parameter int unsigned RAM_SIZE   = 32768,
    parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = ADDR_WIDTH - 1,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic                    start_i,
    input  logic                    dir_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
    output logic                    m_valid_o,
    output logic [DATA_WIDTH-1:0]   m_data_o,
    output logic                    m_last_o,
    input  logic                    m_ready_i,
    input  logic                    s_valid_i,
    input  logic [DATA_WIDTH-1:0]   s_data_i,
    output logic                    s_ready_o
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    dma_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;

    logic [CntW-1:0]       fifo_count;
    dma_word_t             fifo_head;
    dma_word_t             push_word;
    logic                  fifo_nonempty;
    logic                  pop;
    logic                  issue_ok;
    logic                  drained;
    logic [1:0]            unused_base_lsb;

    assign unused_base_lsb = base_addr_i[1:0];

    assign fifo_nonempty = (fifo_count != '0);
    assign pop           = fifo_nonempty & m_ready_i;
    assign push_word     = '{last: inflight_last_q, data: ram_rdata_i};

    // A new read may only be issued if its return is guaranteed a FIFO slot.
    assign issue_ok = ({1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q})
                      < ((CntW + 1)'(FIFO_DEPTH) + {{CntW{1'b0}}, pop});

    assign drained = !inflight_q &&
                     ((fifo_count == '0) || ((fifo_count == CntW'(1)) && pop));

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        busy_o          = 1'b0;
        done_o          = 1'b0;
        ram_en_o        = 1'b0;
        ram_we_o        = 1'b0;
        ram_be_o        = '0;
        ram_addr_o      = '0;
        ram_wdata_o     = '0;
        s_ready_o       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    addr_d = {base_addr_i[ADDR_WIDTH-1:2], 2'b00};
                    rem_d  = len_i;
                    if (len_i == '0) begin
                        state_d = StDone;
                    end else if (dir_i == DIR_WRITE) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                busy_o = 1'b1;
                if (issue_ok) begin
                    ram_en_o        = 1'b1;
                    ram_addr_o      = addr_q;
                    addr_d          = addr_q + ADDR_WIDTH'(WORD_BYTES);
                    rem_d           = rem_q - LEN_WIDTH'(1);
                    inflight_d      = 1'b1;
                    inflight_last_d = (rem_q == LEN_WIDTH'(1));
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = StRdDrain;
                    end
                end
            end
            StRdDrain: begin
                busy_o = 1'b1;
                if (drained) begin
                    state_d = StDone;
                end
            end
            StWr: begin
                busy_o    = 1'b1;
                s_ready_o = (rem_q != '0);
                if (s_valid_i && s_ready_o) begin
                    ram_en_o    = 1'b1;
                    ram_we_o    = 1'b1;
                    ram_be_o    = BE_ALL;
                    ram_addr_o  = addr_q;
                    ram_wdata_o = s_data_i;
                    addr_d      = addr_q + ADDR_WIDTH'(WORD_BYTES);
                    rem_d       = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    dma_stream_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rstn_i  (rstn_i),
        .push_i  (inflight_q),
        .wdata_i (push_word),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count)
    );

    // Head payload is gated so the stream reads as zero when empty.
    assign m_valid_o = fifo_nonempty;
    assign m_data_o  = fifo_nonempty ? fifo_head.data : '0;
    assign m_last_o  = fifo_nonempty & fifo_head.last;

endmodule
